sys_array_feeder: RTL and testbench

Input skew stage placed directly upstream of the systolic array. Accepts one unskewed weight vector and one feature vector per handshake beat and re-times lane k by k beats, producing the diagonal wavefront the array's weight and layer inputs expect. Generates the array `enable`. Flushes the wavefront with zero beats after the last vector, then pulses `done`.

---
 rtl/sysarray_pkg.sv | 15 +
 rtl/skew_line.sv | 36 +++
 rtl/sys_array_feeder.sv | 156 +++++++++++++++
 tb/tb_sys_array_feeder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysarray_pkg.sv
// Shared definitions for the systolic array and its input feeder.
// Holds the feeder FSM state encoding and the default lane geometry.
package sysarray_pkg;

  localparam int SYS_DATA_W = 32;
  localparam int SYS_DIM    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } feedState_e;

endpackage

// File: rtl/skew_line.sv
// Per-lane delay line for the feeder skew network.
// DEPTH stages advance together on shiftEn; DEPTH=0 is a plain wire.
module skew_line
  import sysarray_pkg::*;
#(
  parameter int DEPTH = 0,
  parameter int WIDTH = SYS_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shiftEn,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : gPass
    logic unusedCtrl;
    assign unusedCtrl = clk ^ rst ^ shiftEn;
    assign dout = din;
  end else begin : gLine
    logic signed [WIDTH-1:0] taps [DEPTH];

    // Shift one position per advance; taps[0] holds the newest value
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
      end else if (shiftEn) begin
        taps[0] <= din;
        for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
      end
    end

    assign dout = taps[DEPTH-1];
  end

endmodule

// File: rtl/sys_array_feeder.sv
// Input skew stage for the systolic array: lane k of the weight and feature
// vectors is delayed by k advances to form the diagonal wavefront, then
// registered once. A zero-filled drain of SysDimension-1 advances flushes
// the delay lines before done pulses, so consecutive passes start clean.
// Optional build macro SYSFEED_STALL_CNT_EN adds the stallCount output.
module sys_array_feeder
  import sysarray_pkg::*;
#(
  parameter int dataWidth    = SYS_DATA_W,
  parameter int SysDimension = SYS_DIM,
  parameter int LEN_W        = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [LEN_W-1:0]                 streamLength,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [dataWidth*SysDimension-1:0] weightIn,
  input  logic [dataWidth*SysDimension-1:0] layerIn,
  output logic [dataWidth*SysDimension-1:0] weightArray,
  output logic [dataWidth*SysDimension-1:0] layerArray,
  output logic                             enable,
  output logic                             busy,
  output logic                             done
`ifdef SYSFEED_STALL_CNT_EN
  ,
  output logic [31:0]                      stallCount
`endif
);

  // Last drain index; a one-lane array needs no drain at all.
  localparam logic [LEN_W-1:0] DRAIN_LAST =
    LEN_W'((SysDimension > 1) ? SysDimension - 2 : 0);

  feedState_e       state;
  logic [LEN_W-1:0] lastIdx;
  logic [LEN_W-1:0] beatCnt;

  logic advance_p0;
  logic vld_p1;

  logic signed [dataWidth-1:0] weightFeed_p0 [SysDimension];
  logic signed [dataWidth-1:0] layerFeed_p0  [SysDimension];
  logic signed [dataWidth-1:0] weightSkew_p0 [SysDimension];
  logic signed [dataWidth-1:0] layerSkew_p0  [SysDimension];
  logic signed [dataWidth-1:0] weight_p1     [SysDimension];
  logic signed [dataWidth-1:0] layer_p1      [SysDimension];

  assign advance_p0 = ((state == STREAM) && in_valid) || (state == DRAIN);

  assign in_ready = (state == STREAM);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign enable   = vld_p1;

  // Sequence IDLE -> STREAM -> DRAIN -> DONE; beatCnt counts beats, then drain cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      lastIdx <= '0;
      beatCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            beatCnt <= '0;
            if (streamLength != '0) begin
              lastIdx <= streamLength - LEN_W'(1);
              state   <= STREAM;
            end else begin
              state <= DONE;
            end
          end
        end
        STREAM: begin
          if (in_valid) begin
            if (beatCnt == lastIdx) begin
              beatCnt <= '0;
              state   <= (SysDimension > 1) ? DRAIN : DONE;
            end else begin
              beatCnt <= beatCnt + LEN_W'(1);
            end
          end
        end
        DRAIN: begin
          if (beatCnt == DRAIN_LAST) begin
            beatCnt <= '0;
            state   <= DONE;
          end else begin
            beatCnt <= beatCnt + LEN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- p0: lane feed (zero vectors while draining) and per-lane delay lines
  for (genvar k = 0; k < SysDimension; k++) begin : gLane
    assign weightFeed_p0[k] = (state == STREAM) ? weightIn[k*dataWidth +: dataWidth] : '0;
    assign layerFeed_p0[k]  = (state == STREAM) ? layerIn[k*dataWidth +: dataWidth]  : '0;

    skew_line #(.DEPTH(k), .WIDTH(dataWidth)) weightLine (
      .clk    (clk),
      .rst    (rst),
      .shiftEn(advance_p0),
      .din    (weightFeed_p0[k]),
      .dout   (weightSkew_p0[k])
    );

    skew_line #(.DEPTH(k), .WIDTH(dataWidth)) layerLine (
      .clk    (clk),
      .rst    (rst),
      .shiftEn(advance_p0),
      .din    (layerFeed_p0[k]),
      .dout   (layerSkew_p0[k])
    );

    assign weightArray[k*dataWidth +: dataWidth] = weight_p1[k];
    assign layerArray[k*dataWidth +: dataWidth]  = layer_p1[k];
  end

  // ---- p1: output register, loaded only on an advance so stalls hold the wavefront
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      for (int k = 0; k < SysDimension; k++) begin
        weight_p1[k] <= '0;
        layer_p1[k]  <= '0;
      end
    end else begin
      vld_p1 <= advance_p0;
      if (advance_p0) begin
        for (int k = 0; k < SysDimension; k++) begin
          weight_p1[k] <= weightSkew_p0[k];
          layer_p1[k]  <= layerSkew_p0[k];
        end
      end
    end
  end

`ifdef SYSFEED_STALL_CNT_EN
  // Count STREAM cycles where the source offered no vector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCount <= '0;
    end else if ((state == IDLE) && start) begin
      stallCount <= '0;
    end else if ((state == STREAM) && !in_valid) begin
      stallCount <= stallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sys_array_feeder.sv
// Directed bench for sys_array_feeder (SysDimension=4, dataWidth=8).
// Expected wavefronts are pushed to a scoreboard as beats are driven and
// popped by a negedge monitor on every enable cycle.
module tb_sys_array_feeder;

  localparam int D  = 4;
  localparam int W  = 8;
  localparam int LW = 16;
  localparam int VW = D * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] streamLength;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] weightIn;
  logic [VW-1:0] layerIn;
  logic [VW-1:0] weightArray;
  logic [VW-1:0] layerArray;
  logic          enable;
  logic          busy;
  logic          done;
`ifdef SYSFEED_STALL_CNT_EN
  logic [31:0]   stallCount;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int enCnt = 0;
  int doneCnt = 0;
  int readyCnt = 0;
  int lastGaps = 0;

  logic [VW-1:0] expW[$];
  logic [VW-1:0] expL[$];
  logic [W-1:0]  lane2Q[$];
  logic [VW-1:0] prevW;
  logic [VW-1:0] prevL;
  logic [VW-1:0] passW [8];
  logic [VW-1:0] passL [8];
  logic [W-1:0]  lane2Ref [6];

  sys_array_feeder #(.dataWidth(W), .SysDimension(D), .LEN_W(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .streamLength(streamLength),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .weightIn    (weightIn),
    .layerIn     (layerIn),
    .weightArray (weightArray),
    .layerArray  (layerArray),
    .enable      (enable),
    .busy        (busy),
    .done        (done)
`ifdef SYSFEED_STALL_CNT_EN
    ,
    .stallCount  (stallCount)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected output vector on advance a of a pass of length len with clean delay lines
  function automatic logic [VW-1:0] expAt(input bit isLayer, input int len, input int a);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < D; k++)
      if ((a - k >= 0) && (a - k < len))
        v[k*W +: W] = isLayer ? passL[a-k][k*W +: W] : passW[a-k][k*W +: W];
    return v;
  endfunction

  // Monitor: compare on enable cycles, require hold otherwise
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (enable === 1'b1) begin
        enCnt <= enCnt + 1;
        lane2Q.push_back(weightArray[2*W +: W]);
        if (expW.size() == 0) begin
          chk("enable with nothing expected", 64'(enable), 64'd0);
        end else begin
          chk("weightArray", 64'(weightArray), 64'(expW.pop_front()));
          chk("layerArray", 64'(layerArray), 64'(expL.pop_front()));
        end
      end else begin
        chk("weightArray hold", 64'(weightArray), 64'(prevW));
        chk("layerArray hold", 64'(layerArray), 64'(prevL));
      end
      if (done === 1'b1) doneCnt <= doneCnt + 1;
      if (in_ready === 1'b1) readyCnt <= readyCnt + 1;
    end
    prevW <= weightArray;
    prevL <= layerArray;
  end

  task automatic fillPass(input int len, input bit tens);
    for (int v = 0; v < len; v++) begin
      for (int k = 0; k < D; k++) begin
        passW[v][k*W +: W] = tens ? W'(v * 10 + k) : W'($urandom_range(1, 255));
        passL[v][k*W +: W] = W'($urandom_range(1, 255));
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle after done
  task automatic runPass(input int len, input int maxGap, input bit holdStart);
    int en0, dn0, rd0, startCyc, doneCyc, gaps, g;
    bit seen;
    en0 = enCnt; dn0 = doneCnt; rd0 = readyCnt; gaps = 0;
    start = 1'b1;
    streamLength = LW'(len);
    @(posedge clk); #1;
    startCyc = cyc;
    start = holdStart;
    if (holdStart) streamLength = LW'(1);
    chk("busy after start", 64'(busy), 64'd1);
    chk("in_ready after start", 64'(in_ready), (len > 0) ? 64'd1 : 64'd0);
    for (int i = 0; i < len; i++) begin
      g = (maxGap > 0) ? ((i == 1) ? maxGap : int'($urandom_range(0, maxGap))) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        weightIn = $urandom;
        layerIn  = $urandom;
        @(posedge clk); #1;
      end
      gaps += g;
      chk("in_ready before beat", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      weightIn = passW[i];
      layerIn  = passL[i];
      expW.push_back(expAt(1'b0, len, i));
      expL.push_back(expAt(1'b1, len, i));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    weightIn = $urandom;
    layerIn  = $urandom;
    if (len > 0) begin
      for (int a = len; a < len + D - 1; a++) begin
        expW.push_back(expAt(1'b0, len, a));
        expL.push_back(expAt(1'b1, len, a));
      end
    end
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    doneCyc = cyc;
    start = 1'b0;
    chk("done reached", 64'(seen), 64'd1);
    @(posedge clk); #1;
    chk("pass cycles start..done inclusive", 64'(doneCyc - startCyc + 2),
        (len == 0) ? 64'd2 : 64'(1 + len + gaps + (D - 1) + 1));
    chk("done pulses per pass", 64'(doneCnt - dn0), 64'd1);
    chk("enable pulses per pass", 64'(enCnt - en0), (len == 0) ? 64'd0 : 64'(len + D - 1));
    chk("scoreboard drained", 64'(expW.size()), 64'd0);
    chk("busy after done", 64'(busy), 64'd0);
    chk("done one cycle", 64'(done), 64'd0);
    if (len == 0) chk("in_ready on empty pass", 64'(readyCnt - rd0), 64'd0);
    lastGaps = gaps;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn0;
    lane2Ref = '{8'd0, 8'd0, 8'd2, 8'd12, 8'd22, 8'd0};
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; streamLength = '0;
    weightIn = '0; layerIn = '0;
    #2;
    chk("reset weightArray", 64'(weightArray), 64'd0);
    chk("reset layerArray", 64'(layerArray), 64'd0);
    chk("reset enable", 64'(enable), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Reference pass: weight lanes v*10+k, no stalls
    fillPass(3, 1'b1);
    lane2Q.delete();
    runPass(3, 0, 1'b0);
    chk("lane2 sequence length", 64'(lane2Q.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < lane2Q.size()) chk("lane2 sequence value", 64'(lane2Q[i]), 64'(lane2Ref[i]));
`ifdef SYSFEED_STALL_CNT_EN
    chk("stallCount no stalls", 64'(stallCount), 64'd0);
`endif

    // Empty pass
    runPass(0, 0, 1'b0);

    // Random in_valid gaps
    fillPass(5, 1'b0);
    runPass(5, 2, 1'b0);
`ifdef SYSFEED_STALL_CNT_EN
    chk("stallCount gaps", 64'(stallCount), 64'(lastGaps));
    repeat (3) @(posedge clk); #1;
    chk("stallCount holds", 64'(stallCount), 64'(lastGaps));
`endif

    // Reset after the second accepted beat
    fillPass(5, 1'b0);
    dn0 = doneCnt;
    start = 1'b1; streamLength = LW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; weightIn = passW[i]; layerIn = passL[i];
      expW.push_back(expAt(1'b0, 5, i));
      expL.push_back(expAt(1'b1, 5, i));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("mid reset weightArray", 64'(weightArray), 64'd0);
    chk("mid reset layerArray", 64'(layerArray), 64'd0);
    chk("mid reset enable", 64'(enable), 64'd0);
    chk("mid reset in_ready", 64'(in_ready), 64'd0);
    chk("mid reset busy", 64'(busy), 64'd0);
    chk("mid reset done", 64'(done), 64'd0);
    repeat (2) @(posedge clk); #1;
    expW.delete(); expL.delete();
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("no done after abandoned pass", 64'(doneCnt - dn0), 64'd0);
    chk("idle after reset", 64'(busy), 64'd0);
    fillPass(2, 1'b0);
    runPass(2, 0, 1'b0);

    // Back-to-back passes, start in the cycle after done
    fillPass(2, 1'b0);
    runPass(2, 0, 1'b0);
    fillPass(3, 1'b0);
    runPass(3, 0, 1'b0);

    // start held high through STREAM and DRAIN with a different length
    fillPass(3, 1'b0);
    runPass(3, 0, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("no pass after held start", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
